clint_sched: RTL and testbench

Periodic-tick scheduler for the CLINT timer. It is a Wishbone classic master that owns the mtimecmp registers on the CLINT slave. When enabled, it arms mtimecmp to mtime+period. It re-arms drift-free to previous_cmp+period on every timer interrupt. It sits beside the core's data port on the CLINT Wishbone segment, and the interconnect grants it the CLINT port whenever cyc_o is high.

---
 rtl/clint_sched_pkg.sv | 32 +++
 rtl/clint_sched.sv | 189 ++++++++++++++++++
 tb/tb_clint_sched.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clint_sched_pkg.sv
// Shared types and constants for the CLINT periodic-tick scheduler.
// Holds the FSM state encoding, default CLINT register addresses and the disarm word.
package clint_sched_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StRdHi1,
        StRdLo,
        StRdHi2,
        StCalc,
        StWrLoMax,
        StWrHi,
        StWrLo,
        StCheck,
        StWait,
        StDisLo,
        StDisHi
    } state_e;

    localparam logic [31:0] MTIMECMP_LOW_ADDR  = 32'h2000_0c00;
    localparam logic [31:0] MTIMECMP_HIGH_ADDR = 32'h2000_0c04;
    localparam logic [31:0] MTIME_LOW_ADDR     = 32'h2000_0c08;
    localparam logic [31:0] MTIME_HIGH_ADDR    = 32'h2000_0c0c;

    // Writing this to a mtimecmp word pushes the deadline out of reach.
    localparam logic [31:0] DISARM_WORD = 32'hFFFF_FFFF;

    function automatic logic is_bus_state(input state_e s);
        return s inside {StRdHi1, StRdLo, StRdHi2, StWrLoMax, StWrHi, StWrLo, StDisLo, StDisHi};
    endfunction

endpackage

// File: rtl/clint_sched.sv
// Wishbone master that arms CLINT mtimecmp to mtime+period and re-arms drift-free
// (previous deadline + period) on every timer interrupt.
module clint_sched
    import clint_sched_pkg::*;
#(
    parameter logic [31:0] MtimecmpLowAddr  = MTIMECMP_LOW_ADDR,
    parameter logic [31:0] MtimecmpHighAddr = MTIMECMP_HIGH_ADDR,
    parameter logic [31:0] MtimeLowAddr     = MTIME_LOW_ADDR,
    parameter logic [31:0] MtimeHighAddr    = MTIME_HIGH_ADDR
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [31:0] period_i,
    input  logic        timer_irq_i,
    output logic        cyc_o,
    output logic        stb_o,
    output logic [31:0] adr_o,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    output logic        busy_o,
    output logic        armed_o,
    output logic        tick_o,
    output logic [31:0] tick_cnt_o,
    output logic [15:0] overrun_cnt_o
);

    state_e      r_state;
    logic [63:0] r_cmp;
    logic [31:0] r_hi1;
    logic [31:0] r_lo;
    logic        r_cyc;
    logic [31:0] r_adr;
    logic        r_we;
    logic [31:0] r_dat;
    logic        r_busy;
    logic        r_armed;
    logic        r_tick;
    logic [31:0] r_tick_cnt;
    logic [15:0] r_overrun_cnt;

    state_e      w_state_nxt;
    logic [63:0] w_cmp_nxt;
    logic        w_tick;
    logic        w_overrun;
    logic        w_ack;
    logic [31:0] w_period;
    logic [31:0] w_adr_nxt;
    logic        w_we_nxt;
    logic [31:0] w_dat_nxt;

    assign w_ack    = r_cyc & ack_i;
    assign w_period = (period_i == 32'd0) ? 32'd1 : period_i;

    always_comb begin
        w_state_nxt = r_state;
        w_cmp_nxt   = r_cmp;
        w_tick      = 1'b0;
        w_overrun   = 1'b0;
        unique case (r_state)
            StIdle:    if (en_i) w_state_nxt = StRdHi1;
            StRdHi1:   if (w_ack) w_state_nxt = en_i ? StRdLo : StDisLo;
            StRdLo:    if (w_ack) w_state_nxt = en_i ? StRdHi2 : StDisLo;
            StRdHi2: begin
                if (w_ack) begin
                    if (!en_i) begin
                        w_state_nxt = StDisLo;
                    end else if (dat_i != r_hi1) begin
                        // High word moved under us: the low word may belong to either epoch.
                        w_state_nxt = StRdHi1;
                    end else begin
                        w_state_nxt = StCalc;
                        w_cmp_nxt   = {dat_i, r_lo};
                    end
                end
            end
            StCalc: begin
                w_cmp_nxt   = r_cmp + {32'd0, w_period};
                w_state_nxt = StWrLoMax;
            end
            StWrLoMax: if (w_ack) w_state_nxt = en_i ? StWrHi : StDisLo;
            StWrHi:    if (w_ack) w_state_nxt = en_i ? StWrLo : StDisLo;
            StWrLo:    if (w_ack) w_state_nxt = en_i ? StCheck : StDisLo;
            StCheck: begin
                if (!en_i) begin
                    w_state_nxt = StDisLo;
                end else if (timer_irq_i) begin
                    w_cmp_nxt   = r_cmp + {32'd0, w_period};
                    w_overrun   = 1'b1;
                    w_state_nxt = StWrLoMax;
                end else begin
                    w_state_nxt = StWait;
                end
            end
            StWait: begin
                if (!en_i) begin
                    w_state_nxt = StDisLo;
                end else if (timer_irq_i) begin
                    w_cmp_nxt   = r_cmp + {32'd0, w_period};
                    w_tick      = 1'b1;
                    w_state_nxt = StWrLoMax;
                end
            end
            StDisLo:   if (w_ack) w_state_nxt = StDisHi;
            StDisHi:   if (w_ack) w_state_nxt = StIdle;
            default:   w_state_nxt = StIdle;
        endcase
    end

    // Bus signals are registered from the state being entered.
    always_comb begin
        w_adr_nxt = 32'd0;
        w_we_nxt  = 1'b0;
        w_dat_nxt = 32'd0;
        unique case (w_state_nxt)
            StRdHi1, StRdHi2: w_adr_nxt = MtimeHighAddr;
            StRdLo:           w_adr_nxt = MtimeLowAddr;
            StWrLoMax, StDisLo: begin
                w_adr_nxt = MtimecmpLowAddr;
                w_we_nxt  = 1'b1;
                w_dat_nxt = DISARM_WORD;
            end
            StWrHi: begin
                w_adr_nxt = MtimecmpHighAddr;
                w_we_nxt  = 1'b1;
                w_dat_nxt = w_cmp_nxt[63:32];
            end
            StWrLo: begin
                w_adr_nxt = MtimecmpLowAddr;
                w_we_nxt  = 1'b1;
                w_dat_nxt = w_cmp_nxt[31:0];
            end
            StDisHi: begin
                w_adr_nxt = MtimecmpHighAddr;
                w_we_nxt  = 1'b1;
                w_dat_nxt = DISARM_WORD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= StIdle;
            r_cmp         <= 64'd0;
            r_hi1         <= 32'd0;
            r_lo          <= 32'd0;
            r_cyc         <= 1'b0;
            r_adr         <= 32'd0;
            r_we          <= 1'b0;
            r_dat         <= 32'd0;
            r_busy        <= 1'b0;
            r_armed       <= 1'b0;
            r_tick        <= 1'b0;
            r_tick_cnt    <= 32'd0;
            r_overrun_cnt <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cmp   <= w_cmp_nxt;
            if (r_state == StRdHi1 && w_ack) r_hi1 <= dat_i;
            if (r_state == StRdLo && w_ack) r_lo <= dat_i;
            r_cyc   <= is_bus_state(w_state_nxt);
            r_adr   <= w_adr_nxt;
            r_we    <= w_we_nxt;
            r_dat   <= w_dat_nxt;
            r_busy  <= !(w_state_nxt == StIdle || w_state_nxt == StWait);
            r_armed <= (w_state_nxt == StWait);
            r_tick  <= w_tick;
            if (w_tick) r_tick_cnt <= r_tick_cnt + 32'd1;
            if (w_overrun && r_overrun_cnt != 16'hFFFF) r_overrun_cnt <= r_overrun_cnt + 16'd1;
        end
    end

    assign cyc_o         = r_cyc;
    assign stb_o         = r_cyc;
    assign adr_o         = r_adr;
    assign we_o          = r_we;
    assign sel_o         = 4'hF;
    assign dat_o         = r_dat;
    assign busy_o        = r_busy;
    assign armed_o       = r_armed;
    assign tick_o        = r_tick;
    assign tick_cnt_o    = r_tick_cnt;
    assign overrun_cnt_o = r_overrun_cnt;

endmodule

// File: tb/tb_clint_sched.sv
// Bench for clint_sched: a behavioural CLINT slave (mtime/mtimecmp, wait states) plus
// expected deadlines computed from plain 64-bit arithmetic on the chosen mtime/period.
module tb_clint_sched;
    import clint_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] period;
    logic        irq;
    logic        cyc;
    logic        stb;
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack;
    logic        busy;
    logic        armed;
    logic        tick;
    logic [31:0] tick_cnt;
    logic [15:0] ovr;

    always #5 clk = ~clk;

    clint_sched dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .period_i     (period),
        .timer_irq_i  (irq),
        .cyc_o        (cyc),
        .stb_o        (stb),
        .adr_o        (adr),
        .we_o         (we),
        .sel_o        (sel),
        .dat_o        (dat_o),
        .dat_i        (dat_i),
        .ack_i        (ack),
        .busy_o       (busy),
        .armed_o      (armed),
        .tick_o       (tick),
        .tick_cnt_o   (tick_cnt),
        .overrun_cnt_o(ovr)
    );

    // CLINT slave model; the stimulus process steers it only through these knobs.
    logic [63:0] mtime    = 64'd0;
    logic [63:0] mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF;
    logic [63:0] ld_val   = 64'd0;
    int unsigned ws = 0, wcnt = 0, mt_div = 0, mt_ph = 0;
    int unsigned ld_seq = 0, ld_done = 0, bump_seq = 0, bump_done = 0;
    int unsigned wn = 0, hi_reads = 0, tick_n = 0, cyc_n = 0;
    logic [31:0] wadr [0:511];
    logic [31:0] wdat [0:511];
    int unsigned tick_at [0:63];

    assign ack = stb && (wcnt == ws);
    assign irq = (mtime >= mtimecmp);

    always_comb begin
        dat_i = 32'd0;
        case (adr)
            MTIME_LOW_ADDR:     dat_i = mtime[31:0];
            MTIME_HIGH_ADDR:    dat_i = mtime[63:32];
            MTIMECMP_LOW_ADDR:  dat_i = mtimecmp[31:0];
            MTIMECMP_HIGH_ADDR: dat_i = mtimecmp[63:32];
            default:            dat_i = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        wcnt  <= (stb && !ack) ? wcnt + 1 : 0;
        if (tick) begin
            if (tick_n < 64) tick_at[6'(tick_n)] <= cyc_n;
            tick_n <= tick_n + 1;
        end
        if (stb && ack && we) begin
            if (wn < 512) begin
                wadr[9'(wn)] <= adr;
                wdat[9'(wn)] <= dat_o;
            end
            wn <= wn + 1;
            if (adr == MTIMECMP_LOW_ADDR) mtimecmp[31:0] <= dat_o;
            else if (adr == MTIMECMP_HIGH_ADDR) mtimecmp[63:32] <= dat_o;
        end
        if (stb && ack && !we && adr == MTIME_HIGH_ADDR) hi_reads <= hi_reads + 1;
        if (ld_seq != ld_done) begin
            mtime   <= ld_val;
            ld_done <= ld_seq;
            mt_ph   <= 0;
        end else if (bump_seq != bump_done && stb && ack && !we && adr == MTIME_HIGH_ADDR) begin
            mtime     <= mtime + 64'd1;
            bump_done <= bump_seq;
        end else if (mt_div != 0) begin
            if (mt_ph + 1 >= mt_div) begin
                mt_ph <= 0;
                mtime <= mtime + 64'd1;
            end else begin
                mt_ph <= mt_ph + 1;
            end
        end
    end

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] tri_cmp(input int unsigned idx);
        return {wdat[9'(idx + 1)], wdat[9'(idx + 2)]};
    endfunction

    task automatic check_arm(input string tag, input int unsigned idx, input logic [63:0] cmp);
        check({tag, "_w0"}, {wadr[9'(idx)], wdat[9'(idx)]}, {MTIMECMP_LOW_ADDR, DISARM_WORD});
        check({tag, "_w1"}, {wadr[9'(idx + 1)], wdat[9'(idx + 1)]},
              {MTIMECMP_HIGH_ADDR, cmp[63:32]});
        check({tag, "_w2"}, {wadr[9'(idx + 2)], wdat[9'(idx + 2)]},
              {MTIMECMP_LOW_ADDR, cmp[31:0]});
    endtask

    task automatic wait_armed(input string tag, input int unsigned bound);
        int unsigned k = 0;
        while (armed !== 1'b1 && k < bound) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_armed"}, 64'(armed), 64'd1);
    endtask

    task automatic go_idle(input string tag);
        int unsigned k = 0;
        en = 1'b0;
        while ((busy !== 1'b0 || armed !== 1'b0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_idle"}, 64'(busy | armed), 64'd0);
    endtask

    initial begin
        logic [63:0] m;
        logic [63:0] c;
        logic [63:0] e;
        logic [31:0] p;
        logic [15:0] ovr0;
        int unsigned base, b2, k, o0, n0;

        rst    = 1'b1;
        en     = 1'b0;
        period = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_cyc", 64'(cyc), 64'd0);
        check("rst_stb", 64'(stb), 64'd0);
        check("rst_we", 64'(we), 64'd0);
        check("rst_adr", 64'(adr), 64'd0);
        check("rst_dat", 64'(dat_o), 64'd0);
        check("rst_sel", 64'(sel), 64'hF);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_armed", 64'(armed), 64'd0);
        check("rst_tick", 64'(tick), 64'd0);
        check("rst_tick_cnt", 64'(tick_cnt), 64'd0);
        check("rst_ovr", 64'(ovr), 64'd0);

        // First arm from a frozen mtime: 9 cycles from enable to armed.
        ld_val = 64'h10;
        ld_seq++;
        period = 32'd100;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        base = wn;
        en   = 1'b1;
        repeat (8) @(negedge clk);
        check("arm_8cyc", 64'(armed), 64'd0);
        @(negedge clk);
        check("arm_9cyc", 64'(armed), 64'd1);
        check("arm_nwr", 64'(wn - base), 64'd3);
        check_arm("arm", base, 64'h74);
        check("arm_irq", 64'(irq), 64'd0);

        // Periodic ticking; new period applies from the first re-arm.
        p      = $urandom_range(8, 2);
        period = p;
        base   = wn;
        b2     = tick_n;
        ld_val = 64'h70;
        ld_seq++;
        mt_div = 4;
        k      = 0;
        while (tick_n < b2 + 3 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("per_ticks", 64'(tick_n - b2), 64'd3);
        repeat (6) @(negedge clk);
        check("per_tick_cnt", 64'(tick_cnt), 64'd3);
        check("per_gap1", 64'(tick_at[6'(b2 + 1)] - tick_at[6'(b2)]), 64'(4 * p));
        check("per_gap2", 64'(tick_at[6'(b2 + 2)] - tick_at[6'(b2 + 1)]), 64'(4 * p));
        check("per_nwr", 64'(wn - base), 64'd9);
        c = 64'h74;
        for (int i = 0; i < 3; i++) begin
            c = c + 64'(p);
            check_arm("per", base + 3 * i, c);
        end
        check("per_ovr", 64'(ovr), 64'd0);

        // High word rolls over between the two high reads: one retry.
        mt_div = 0;
        go_idle("roll");
        p        = $urandom_range(1000, 1);
        period   = p;
        ld_val   = 64'h0000_0000_FFFF_FFFF;
        ld_seq++;
        bump_seq++;
        repeat (2) @(negedge clk);
        o0 = hi_reads;
        en = 1'b1;
        wait_armed("roll", 100);
        check("roll_hi_reads", 64'(hi_reads - o0), 64'd4);
        check_arm("roll", wn - 3, 64'h1_0000_0000 + 64'(p));

        // Overrun: period 0 acts as 1 while mtime outruns the deadline.
        go_idle("ovr");
        period = 32'd0;
        ld_val = {32'd0, 32'($urandom_range(32'h0001_0000, 32'h0000_1000))};
        ld_seq++;
        mt_div = 1;
        @(negedge clk);
        base = wn;
        en   = 1'b1;
        k    = 0;
        while (wn - base < 12 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("ovr_nwr", 64'(wn - base >= 12), 64'd1);
        check("ovr_step1", tri_cmp(base + 3) - tri_cmp(base), 64'd1);
        check("ovr_step2", tri_cmp(base + 6) - tri_cmp(base + 3), 64'd1);
        check("ovr_step3", tri_cmp(base + 9) - tri_cmp(base + 6), 64'd1);
        ovr0 = ovr;
        repeat (40) @(negedge clk);
        check("ovr_rate", 64'(ovr - ovr0), 64'd10);
        period = 32'd1000;
        wait_armed("ovr_catch", 100);
        check("ovr_final_step", tri_cmp(wn - 3) - tri_cmp(wn - 6), 64'd1000);
        ovr0 = ovr;
        repeat (20) @(negedge clk);
        check("ovr_stop", 64'(ovr), 64'(ovr0));
        check("ovr_irq", 64'(irq), 64'd0);
        check("ovr_tick_cnt", 64'(tick_cnt), 64'd3);
        mt_div = 0;

        // Disable during WR_HI with two wait states.
        go_idle("dis");
        ws     = 2;
        p      = $urandom_range(1000, 1);
        period = p;
        m      = {32'($urandom), 32'($urandom_range(32'h0010_0000, 0))};
        e      = m + 64'(p);
        ld_val = m;
        ld_seq++;
        @(negedge clk);
        base = wn;
        en   = 1'b1;
        k    = 0;
        while (!(cyc === 1'b1 && we === 1'b1 && adr === MTIMECMP_HIGH_ADDR) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("dis_saw_wrhi", 64'(adr), 64'(MTIMECMP_HIGH_ADDR));
        en = 1'b0;
        k  = 0;
        while (busy !== 1'b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check("dis_nwr", 64'(wn - base), 64'd4);
        check("dis_w0", {wadr[9'(base)], wdat[9'(base)]}, {MTIMECMP_LOW_ADDR, DISARM_WORD});
        check("dis_w1", {wadr[9'(base + 1)], wdat[9'(base + 1)]}, {MTIMECMP_HIGH_ADDR, e[63:32]});
        check("dis_w2", {wadr[9'(base + 2)], wdat[9'(base + 2)]},
              {MTIMECMP_LOW_ADDR, DISARM_WORD});
        check("dis_w3", {wadr[9'(base + 3)], wdat[9'(base + 3)]},
              {MTIMECMP_HIGH_ADDR, DISARM_WORD});
        check("dis_armed", 64'(armed), 64'd0);
        check("dis_irq", 64'(irq), 64'd0);

        // Reset while WR_LO waits for ack; then re-arm from a fresh mtime read.
        p      = $urandom_range(1000, 1);
        period = p;
        m      = {32'($urandom), 32'($urandom_range(32'h0010_0000, 0))};
        e      = m + 64'(p);
        ld_val = m;
        ld_seq++;
        @(negedge clk);
        en = 1'b1;
        k  = 0;
        while (!(cyc === 1'b1 && we === 1'b1 && adr === MTIMECMP_LOW_ADDR && dat_o === e[31:0])
               && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("rmid_saw_wrlo", 64'(dat_o), 64'(e[31:0]));
        n0  = wn;
        rst = 1'b1;
        @(negedge clk);
        check("rmid_cyc", 64'(cyc), 64'd0);
        check("rmid_stb", 64'(stb), 64'd0);
        check("rmid_tick_cnt", 64'(tick_cnt), 64'd0);
        check("rmid_ovr", 64'(ovr), 64'd0);
        check("rmid_busy", 64'(busy), 64'd0);
        check("rmid_nowrite", 64'(wn - n0), 64'd0);
        check("rmid_cmp_partial", mtimecmp, {e[63:32], DISARM_WORD});
        m      = {32'($urandom), 32'($urandom_range(32'h0010_0000, 0))};
        ld_val = m;
        ld_seq++;
        @(negedge clk);
        ws   = 0;
        o0   = hi_reads;
        base = wn;
        rst  = 1'b0;
        wait_armed("rearm", 100);
        check("rearm_hi_reads", 64'(hi_reads - o0), 64'd2);
        check("rearm_nwr", 64'(wn - base), 64'd3);
        check_arm("rearm", base, m + 64'(p));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
